// File: rtl/multiplier_32x16_seq.sv
// multiplier_32x16_seq: sequential shift-add multiply-accumulate, product = q*b + r.
// Rebuilds a dividend from 32/16 divider outputs; one operation in flight,
// valid/ready handshake on both sides.
// Build option: MUL_RADIX4_EN retires two multiplier bits per step (BW/2 steps)
// using a 3*q register captured at accept; otherwise one bit per step (BW steps).
module multiplier_32x16_seq #(
   parameter int QW = 32,
   parameter int BW = 16,   // must be even
   parameter int RW = 32    // RW <= QW+BW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [QW-1:0]    q,
   input  logic [BW-1:0]    b,
   input  logic [RW-1:0]    r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW+BW-1:0] product,
   output logic             ovf
);

   localparam int PW = QW + BW;
`ifdef MUL_RADIX4_EN
   localparam int STEPS = BW / 2;
`else
   localparam int STEPS = BW;
`endif
   localparam int CW = $clog2(STEPS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] mcand;
   logic [BW-1:0] mplier;
   logic [PW-1:0] acc;
   logic [PW-1:0] acc_n;
   logic [CW-1:0] count;
   logic          last_step;

   // Handshake flags come straight from the state register, so neither
   // in_valid nor out_ready has a combinational path to them.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign last_step = (count == CW'(STEPS - 1));

`ifdef MUL_RADIX4_EN
   logic [QW+1:0] q_ext;
   logic [QW+1:0] mcand3;   // 3*q, shifted into place by the step count

   assign q_ext = {2'b00, q};

   // Radix-4 step: add 0, 1x, 2x or 3x the current (shifted) multiplicand.
   always_comb begin
      acc_n = acc;
      case (mplier[1:0])
         2'd1:    acc_n = acc + mcand;
         2'd2:    acc_n = acc + (mcand << 1);
         2'd3:    acc_n = acc + (PW'(mcand3) << {count, 1'b0});
         default: acc_n = acc;
      endcase
   end
`else
   // Radix-2 step: add the multiplicand when the low multiplier bit is set.
   always_comb begin
      acc_n = acc;
      if (mplier[0]) acc_n = acc + mcand;
   end
`endif

   // FSM and datapath; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
         ovf     <= 1'b0;
`ifdef MUL_RADIX4_EN
         mcand3  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mcand  <= PW'(q);
                  mplier <= b;
                  acc    <= PW'(r);
                  count  <= '0;
`ifdef MUL_RADIX4_EN
                  mcand3 <= (q_ext << 1) + q_ext;
`endif
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= acc_n;
               count <= count + 1'b1;
`ifdef MUL_RADIX4_EN
               mcand  <= mcand << 2;
               mplier <= mplier >> 2;
`else
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
`endif
               // Final step publishes the result in the same edge.
               if (last_step) begin
                  product <= acc_n;
                  ovf     <= |(acc_n >> 32);
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_32x16_seq.sv
module tb_multiplier_32x16_seq;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] q;
  logic [15:0] b;
  logic [31:0] r;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiplier_32x16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .b         (b),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  task automatic start_op(input logic [31:0] qi, input logic [15:0] bi,
                          input logic [31:0] ri, output int lat);
    in_valid = 1'b1; q = qi; b = bi; r = ri;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = $urandom; b = 16'($urandom); r = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [47:0] held;
    logic [31:0] a;
    logic [15:0] d;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; b = '0; r = '0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $error("FAIL rst_in_ready: got %0h", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $error("FAIL rst_out_valid: got %0h", out_valid); end
    total++; if (product !== 48'h0) begin bad++; $error("FAIL rst_product: got %0h", product); end
    total++; if (ovf !== 1'b0) begin bad++; $error("FAIL rst_ovf: got %0h", ovf); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    total++; if (in_ready !== 1'b1) begin bad++; $error("FAIL basic_in_ready: got %0h", in_ready); end
    start_op(32'h0000_1234, 16'h0010, 32'h5, lat);
    total++; if (lat !== LAT) begin bad++; $error("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    total++; if (product !== 48'h0000_0001_2345) begin bad++; $error("FAIL basic_product: got %0h", product); end
    total++; if (ovf !== 1'b0) begin bad++; $error("FAIL basic_ovf: got %0h", ovf); end
    handshake();

    start_op(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, lat);
    total++; if (lat !== LAT) begin bad++; $error("FAIL max_latency: got %0d expected %0d", lat, LAT); end
    total++; if (product !== 48'hFFFF_FFFF_0000) begin bad++; $error("FAIL max_product: got %0h", product); end
    total++; if (ovf !== 1'b1) begin bad++; $error("FAIL max_ovf: got %0h", ovf); end
    handshake();

    start_op(32'h0001_0000, 16'h0003, 32'h1, lat);
    held = product;
    total++; if (held !== 48'h0000_0003_0001) begin bad++; $error("FAIL bp_product: got %0h", held); end
    seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0) begin
        bad++; seen++;
        $error("FAIL bp_hold cycle %0d: ov=%0h p=%0h ir=%0h", i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    total++; if (seen !== 0) begin bad++; $error("FAIL bp_stable: got %0d", seen); end
    handshake();
    total++; if (out_valid !== 1'b0) begin bad++; $error("FAIL bp_out_valid_drop: got %0h", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $error("FAIL bp_in_ready_back: got %0h", in_ready); end
    total++; if (product !== held) begin bad++; $error("FAIL bp_product_hold: got %0h expected %0h", product, held); end

    start_op(32'hDEAD_BEEF, 16'h0000, 32'h7, lat);
    total++; if (lat !== LAT) begin bad++; $error("FAIL b0_latency: got %0d expected %0d", lat, LAT); end
    total++; if (product !== 48'h7) begin bad++; $error("FAIL b0_product: got %0h", product); end
    total++; if (ovf !== 1'b0) begin bad++; $error("FAIL b0_ovf: got %0h", ovf); end
    handshake();

    start_op(32'h0, 16'h1234, 32'hCAFE_F00D, lat);
    total++; if (product !== 48'h0000_CAFE_F00D) begin bad++; $error("FAIL q0_product: got %0h", product); end
    handshake();

    in_valid = 1'b1; q = 32'h1234_5678; b = 16'h9ABC; r = 32'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $error("FAIL midrst_in_ready: got %0h", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $error("FAIL midrst_out_valid: got %0h", out_valid); end
    total++; if (product !== 48'h0) begin bad++; $error("FAIL midrst_product: got %0h", product); end
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $error("FAIL midrst_no_valid: got %0d", seen); end

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      d = 16'($urandom_range(1, 65535));
      start_op(a / 32'(d), d, a % 32'(d), lat);
      total++;
      if (product !== {16'h0, a}) begin
        bad++; $error("FAIL rt_product: got %0h expected %0h", product, {16'h0, a});
      end
      total++;
      if (ovf !== 1'b0) begin
        bad++; $error("FAIL rt_ovf: got %0h", ovf);
      end
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
